usb_cmd_decoder: RTL

- Downstream consumer of the USB FIFO master's received-word stream: the 16-bit word plus its one-cycle write strobe.
- Frames the stream into fixed 4-word command packets, verifies them, and issues single-cycle register write/read strobes to the local register bank.
- Counts framing errors for host diagnostics; sits between the USB FIFO master and the register/GPIO block.

---
 rtl/usb_cmd_decoder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/usb_cmd_decoder.sv
// usb_cmd_decoder: frames the USB FIFO master's received-word stream into
// 4-word command packets and turns good packets into single-cycle register
// write/read strobes.
//
// Packet: W0 = SYNC_WORD, W1 = {cmd, addr}, W2 = data, W3 = (W1 + W2) mod 2^16.
//
// Ports:
//   CLK        system clock, rising edge
//   resetn     synchronous active-low reset
//   rx_data    received word
//   rx_valid   one-cycle strobe qualifying rx_data
//   reg_addr   address of the last executed command (held)
//   reg_wdata  data of the last executed command (held)
//   reg_wr     one-cycle register write strobe
//   reg_rd     one-cycle register read strobe
//   busy       high while a packet is in progress
//   err_cnt    saturating count of aborted packets
//   last_err   cause of the latest abort: 0 none, 1 checksum, 2 bad cmd, 3 timeout
module usb_cmd_decoder #(
  parameter logic [15:0] SYNC_WORD      = 16'hA55A,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter logic [7:0]  CMD_WR         = 8'h01,
  parameter logic [7:0]  CMD_RD         = 8'h02
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  output logic        busy,
  output logic [7:0]  err_cnt,
  output logic [1:0]  last_err
);

  typedef enum logic [1:0] {StIdle, StHdr, StData, StCsum} state_e;

  state_e      state;
  logic [15:0] tmo_cnt;
  logic [15:0] hdr_word;
  logic [15:0] data_word;

  logic        timeout_hit;
  logic        csum_ok;
  logic        cmd_ok;
  logic [7:0]  err_cnt_inc;

  // A word arriving on the expiry cycle wins over the timeout.
  assign timeout_hit = (state != StIdle) && !rx_valid &&
                       (tmo_cnt == TIMEOUT_CYCLES - 16'd1);
  assign csum_ok     = (rx_data == hdr_word + data_word);
  assign cmd_ok      = (hdr_word[15:8] == CMD_WR) || (hdr_word[15:8] == CMD_RD);
  assign err_cnt_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state     <= StIdle;
      tmo_cnt   <= '0;
      hdr_word  <= '0;
      data_word <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
      err_cnt   <= '0;
      last_err  <= '0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;

      if (state == StIdle || rx_valid) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end

      if (timeout_hit) begin
        state    <= StIdle;
        busy     <= 1'b0;
        tmo_cnt  <= '0;
        err_cnt  <= err_cnt_inc;
        last_err <= 2'd3;
      end else if (rx_valid) begin
        unique case (state)
          StIdle: begin
            // Non-sync words outside a packet are dropped silently.
            if (rx_data == SYNC_WORD) begin
              state <= StHdr;
              busy  <= 1'b1;
            end
          end
          StHdr: begin
            hdr_word <= rx_data;
            state    <= StData;
          end
          StData: begin
            data_word <= rx_data;
            state     <= StCsum;
          end
          StCsum: begin
            state <= StIdle;
            busy  <= 1'b0;
            // Checksum failure is reported ahead of a bad command code.
            if (!csum_ok) begin
              err_cnt  <= err_cnt_inc;
              last_err <= 2'd1;
            end else if (!cmd_ok) begin
              err_cnt  <= err_cnt_inc;
              last_err <= 2'd2;
            end else begin
              reg_addr  <= hdr_word[7:0];
              reg_wdata <= data_word;
              reg_wr    <= (hdr_word[15:8] == CMD_WR);
              reg_rd    <= (hdr_word[15:8] == CMD_RD);
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
